// File: rtl/dm_param_if.sv
// dm_param_if -- request/response bus between a requester and dm_param.
//
// Handshake: a request is accepted on a rising clk edge where req=1 and
// ready=1; we/addr/size/sext/din are captured on that same edge. While
// ready=0 the slave ignores req entirely (nothing is queued). Each accepted
// request produces exactly one single-cycle ack; err qualifies that ack.
// dout carries load data from its ack cycle until the next successful load.
//
// Signals:
//   req, we, addr[ADDR_W], size[2], sext, din[32]  master -> slave
//   ready, ack, err, dout[32]                      slave  -> master
interface dm_param_if #(
    parameter int ADDR_W = 12
) ();
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [1:0]        size;
    logic              sext;
    logic [31:0]       din;
    logic              ready;
    logic              ack;
    logic              err;
    logic [31:0]       dout;

    modport master (
        output req, we, addr, size, sext, din,
        input  ready, ack, err, dout
    );

    modport slave (
        input  req, we, addr, size, sext, din,
        output ready, ack, err, dout
    );
endinterface

// File: rtl/dm_param.sv
// dm_param -- word-organised data memory with byte/halfword/word access,
// configurable wait states and optional misalignment checking.
//
// Parameters:
//   ADDR_W    byte-address width; memory holds 2^(ADDR_W-2) 32-bit words
//   WAIT_CYC  wait states per access (0..15)
// Optional feature macro:
//   DM_PARAM_ALIGN_CHK_EN  misaligned half/word accesses complete at once
//                          with ack=err=1; otherwise low address bits are
//                          forced to alignment and err stays 0.
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset (memory contents are kept)
//   bus        dm_param_if slave modport (req/we/addr/size/sext/din in,
//              ready/ack/err/dout out)
//   dbg_state  current FSM state (0=IDLE, 1=WAIT, 2=ACCESS)
module dm_param #(
    parameter int ADDR_W   = 12,
    parameter int WAIT_CYC = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    dm_param_if.slave  bus,
    output logic [1:0] dbg_state
);
    localparam int DEPTH = 1 << (ADDR_W - 2);
    // Counter preload: WAIT lasts cnt+1 cycles, so load WAIT_CYC-1.
    localparam logic [3:0] WAIT_LD = (WAIT_CYC > 0) ? 4'(WAIT_CYC - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_ACCESS = 2'd2
    } state_t;

    state_t            state;
    logic [3:0]        cnt;
    logic              ready_r;
    logic              ack_r;
    logic              err_r;
    logic [31:0]       dout_r;

    logic              we_l;
    logic              sext_l;
    logic [1:0]        size_l;
    logic [1:0]        lane_l;
    logic [ADDR_W-3:0] idx_l;
    logic [31:0]       din_l;

    logic [31:0]       mem [DEPTH];

    logic [1:0]        lane_in;
    logic              mis;
    logic [31:0]       mask;
    logic [31:0]       wdata;
    logic [31:0]       rword;
    logic [31:0]       shifted;
    logic [31:0]       ld_data;

    // Lane selection and misalignment decision for the incoming request.
    always_comb begin
        lane_in = bus.addr[1:0];
        mis     = 1'b0;
`ifdef DM_PARAM_ALIGN_CHK_EN
        if (bus.size == 2'b01)
            mis = bus.addr[0];
        else if (bus.size[1])
            mis = |bus.addr[1:0];
`else
        if (bus.size == 2'b01)
            lane_in[0] = 1'b0;
        else if (bus.size[1])
            lane_in = 2'b00;
`endif
    end

    // Store lanes: data is replicated across lanes and the mask picks the
    // addressed ones, so untouched lanes keep their old contents.
    always_comb begin
        case (size_l)
            2'b00: begin
                mask  = 32'h0000_00FF << {lane_l, 3'b000};
                wdata = {4{din_l[7:0]}};
            end
            2'b01: begin
                mask  = lane_l[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
                wdata = {2{din_l[15:0]}};
            end
            default: begin
                mask  = 32'hFFFF_FFFF;
                wdata = din_l;
            end
        endcase
    end

    // Load path: right-justify the addressed lane(s), then extend.
    always_comb begin
        rword   = mem[idx_l];
        shifted = rword >> {lane_l, 3'b000};
        case (size_l)
            2'b00:   ld_data = sext_l ? {{24{shifted[7]}}, shifted[7:0]}
                                      : {24'b0, shifted[7:0]};
            2'b01:   ld_data = sext_l ? {{16{shifted[15]}}, shifted[15:0]}
                                      : {16'b0, shifted[15:0]};
            default: ld_data = rword;
        endcase
    end

    // Memory has no reset; the rst_n term keeps an access edge that
    // coincides with reset from writing.
    always_ff @(posedge clk) begin
        if (state == S_ACCESS && we_l && rst_n)
            mem[idx_l] <= (mem[idx_l] & ~mask) | (wdata & mask);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            cnt     <= 4'd0;
            ready_r <= 1'b1;
            ack_r   <= 1'b0;
            err_r   <= 1'b0;
            dout_r  <= 32'd0;
            we_l    <= 1'b0;
            sext_l  <= 1'b0;
            size_l  <= 2'b00;
            lane_l  <= 2'b00;
            idx_l   <= '0;
            din_l   <= 32'd0;
        end else begin
            ack_r <= 1'b0;
            err_r <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.req && ready_r) begin
                        we_l   <= bus.we;
                        sext_l <= bus.sext;
                        size_l <= bus.size;
                        lane_l <= lane_in;
                        idx_l  <= bus.addr[ADDR_W-1:2];
                        din_l  <= bus.din;
                        if (mis) begin
                            // Misaligned: complete next cycle, stay in IDLE.
                            ack_r <= 1'b1;
                            err_r <= 1'b1;
                        end else if (WAIT_CYC == 0) begin
                            state   <= S_ACCESS;
                            ready_r <= 1'b0;
                        end else begin
                            state   <= S_WAIT;
                            cnt     <= WAIT_LD;
                            ready_r <= 1'b0;
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt == 4'd0)
                        state <= S_ACCESS;
                    else
                        cnt <= cnt - 4'd1;
                end
                S_ACCESS: begin
                    state   <= S_IDLE;
                    ready_r <= 1'b1;
                    ack_r   <= 1'b1;
                    if (!we_l)
                        dout_r <= ld_data;
                end
                default: begin
                    state   <= S_IDLE;
                    ready_r <= 1'b1;
                    cnt     <= 4'd0;
                end
            endcase
        end
    end

    assign bus.ready = ready_r;
    assign bus.ack   = ack_r;
    assign bus.err   = err_r;
    assign bus.dout  = dout_r;
    assign dbg_state = state;
endmodule
